// File: rtl/svm_pkg.sv
// Shared constants and types for the HOG/SVM classifier datapath.
package svm_pkg;

  localparam int unsigned HOG_DESC_LEN   = 3780;
  localparam int unsigned SVM_ADDR_W     = 12;
  localparam int unsigned SVM_MAC_CYCLES = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/svm_hold_counter.sv
// Modulo-HOLD counter with enable and synchronous clear; terminal count marks
// the last enabled cycle of a hold period.
module svm_hold_counter #(
  parameter int unsigned HOLD = 10
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iClr,
  output logic oTc
);

  localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(HOLD - 1);

  logic [CntW-1:0] cntQ, cntD;

  // Qualified by enable so a stalled cycle never reports terminal count.
  assign oTc = iEn && (cntQ == TcVal);

  always_comb begin
    cntD = cntQ;
    if (iClr) begin
      cntD = '0;
    end else if (iEn) begin
      cntD = oTc ? '0 : cntQ + 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

endmodule

// File: rtl/svm_weight_addr_seq.sv
// Weight-ROM address sequencer: sweeps DEPTH addresses from a latched base,
// holding each for HOLD cycles, repeated PASSES times per start.
module svm_weight_addr_seq
  import svm_pkg::*;
#(
  parameter int unsigned ADDR_W = SVM_ADDR_W,
  parameter int unsigned DEPTH  = HOG_DESC_LEN,
  parameter int unsigned HOLD   = SVM_MAC_CYCLES,
  parameter int unsigned PASSES = 1,
  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iStall,
  input  logic [ADDR_W-1:0] iBase,
  output logic [ADDR_W-1:0] oADDR,
  output logic              oVALID,
  output logic              oSTROBE,
  output logic              oLAST,
  output logic [PASS_W-1:0] oPASS,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(DEPTH - 1);
  localparam logic [PASS_W-1:0] LastPass = PASS_W'(PASSES - 1);

  seq_state_t        stateQ, stateD;
  logic [ADDR_W-1:0] addrQ, addrD, baseQ, baseD;
  logic [IdxW-1:0]   idxQ, idxD;
  logic [PASS_W-1:0] passQ, passD;
  logic              holdEn, holdClr, holdTc;

  assign holdEn = (stateQ == RUN) && !iStall;

  svm_hold_counter #(
    .HOLD (HOLD)
  ) uHoldCnt (
    .iClk (iClk),
    .iRst (iRst),
    .iEn  (holdEn),
    .iClr (holdClr),
    .oTc  (holdTc)
  );

  always_comb begin
    stateD  = stateQ;
    addrD   = addrQ;
    baseD   = baseQ;
    idxD    = idxQ;
    passD   = passQ;
    holdClr = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (iStart) begin
          baseD   = iBase;
          addrD   = iBase;
          idxD    = '0;
          passD   = '0;
          holdClr = 1'b1;
          stateD  = RUN;
        end
      end
      RUN: begin
        if (holdTc) begin
          if (idxQ != LastIdx) begin
            idxD  = idxQ + 1'b1;
            addrD = addrQ + 1'b1;
          end else if (passQ != LastPass) begin
            passD = passQ + 1'b1;
            idxD  = '0;
            addrD = baseQ;
          end else begin
            // Address is left on the final entry through DONE and IDLE.
            stateD = DONE;
          end
        end
      end
      DONE: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ <= IDLE;
      addrQ  <= '0;
      baseQ  <= '0;
      idxQ   <= '0;
      passQ  <= '0;
    end else begin
      stateQ <= stateD;
      addrQ  <= addrD;
      baseQ  <= baseD;
      idxQ   <= idxD;
      passQ  <= passD;
    end
  end

  assign oADDR   = addrQ;
  assign oPASS   = passQ;
  assign oVALID  = (stateQ == RUN);
  assign oBUSY   = (stateQ != IDLE);
  assign oDONE   = (stateQ == DONE);
  assign oSTROBE = holdTc;
  assign oLAST   = holdTc && (idxQ == LastIdx);

endmodule

// File: tb/tb_svm_weight_addr_seq.sv
// Directed bench for svm_weight_addr_seq across four parameter sets.
module tb_svm_weight_addr_seq;

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  pass;
    logic        valid;
    logic        strobe;
    logic        last;
    logic        busy;
    logic        done;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [11:0] base;
  int          sel;
  int          testsRun = 0;
  int          testsFailed = 0;

  logic [11:0] addr [4];
  logic        passA, passC, passD;
  logic [1:0]  passB;
  logic [3:0]  valid, strobe, last, busy, done;
  obs_t        obs;

  always #5 clk = ~clk;

  // A: defaults; B: DEPTH 4 HOLD 1 PASSES 3; C: DEPTH 4 HOLD 3; D: DEPTH 4 HOLD 1
  svm_weight_addr_seq uDutA (
    .iClk (clk), .iRst (rst), .iStart (start && (sel == 0)), .iStall (stall && (sel == 0)),
    .iBase (base), .oADDR (addr[0]), .oVALID (valid[0]), .oSTROBE (strobe[0]),
    .oLAST (last[0]), .oPASS (passA), .oBUSY (busy[0]), .oDONE (done[0])
  );

  svm_weight_addr_seq #(.DEPTH (4), .HOLD (1), .PASSES (3)) uDutB (
    .iClk (clk), .iRst (rst), .iStart (start && (sel == 1)), .iStall (stall && (sel == 1)),
    .iBase (base), .oADDR (addr[1]), .oVALID (valid[1]), .oSTROBE (strobe[1]),
    .oLAST (last[1]), .oPASS (passB), .oBUSY (busy[1]), .oDONE (done[1])
  );

  svm_weight_addr_seq #(.DEPTH (4), .HOLD (3), .PASSES (1)) uDutC (
    .iClk (clk), .iRst (rst), .iStart (start && (sel == 2)), .iStall (stall && (sel == 2)),
    .iBase (base), .oADDR (addr[2]), .oVALID (valid[2]), .oSTROBE (strobe[2]),
    .oLAST (last[2]), .oPASS (passC), .oBUSY (busy[2]), .oDONE (done[2])
  );

  svm_weight_addr_seq #(.DEPTH (4), .HOLD (1), .PASSES (1)) uDutD (
    .iClk (clk), .iRst (rst), .iStart (start && (sel == 3)), .iStall (stall && (sel == 3)),
    .iBase (base), .oADDR (addr[3]), .oVALID (valid[3]), .oSTROBE (strobe[3]),
    .oLAST (last[3]), .oPASS (passD), .oBUSY (busy[3]), .oDONE (done[3])
  );

  always_comb begin
    obs = '0;
    case (sel)
      0: obs = {addr[0], 1'b0, passA, valid[0], strobe[0], last[0], busy[0], done[0]};
      1: obs = {addr[1], passB, valid[1], strobe[1], last[1], busy[1], done[1]};
      2: obs = {addr[2], 1'b0, passC, valid[2], strobe[2], last[2], busy[2], done[2]};
      3: obs = {addr[3], 1'b0, passD, valid[3], strobe[3], last[3], busy[3], done[3]};
      default: obs = '0;
    endcase
  end

  // Expected outputs for the e-th unstalled cycle after the accepted start edge.
  function automatic obs_t expect_at(input int depth, input int hold, input int passes,
                                     input int b, input int e);
    obs_t o;
    int t, j, idx;
    o = '0;
    t = passes * depth * hold;
    if (e >= 1 && e <= t) begin
      j        = e - 1;
      idx      = (j % (depth * hold)) / hold;
      o.addr   = 12'((b + idx) % 4096);
      o.pass   = 2'(j / (depth * hold));
      o.valid  = 1'b1;
      o.busy   = 1'b1;
      o.strobe = (j % hold) == hold - 1;
      o.last   = o.strobe && (idx == depth - 1);
    end else if (e > t) begin
      o.addr = 12'((b + depth - 1) % 4096);
      o.pass = 2'(passes - 1);
      o.done = (e == t + 1);
      o.busy = o.done;
    end
    return o;
  endfunction

  task automatic run_seq(input string name, input int s, input int depth, input int hold,
                         input int passes, input int b, input int ncyc, input int st0,
                         input int stn, input int extraStart);
    obs_t e, firstGot, firstExp;
    int   eff, bad, firstCyc, dones, lasts;
    bad = 0; firstCyc = 0; dones = 0; lasts = 0; firstGot = '0; firstExp = '0;
    sel = s; base = 12'(b); start = 1'b1; stall = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int r = 1; r <= ncyc; r++) begin
      stall = (stn > 0) && (r >= st0) && (r < st0 + stn);
      start = (r == extraStart);
      eff = (stn == 0 || r < st0) ? r : ((r >= st0 + stn) ? r - stn : st0);
      e = expect_at(depth, hold, passes, b, eff);
      if (stall) begin
        e.strobe = 1'b0;
        e.last   = 1'b0;
      end
      @(negedge clk);
      if (obs !== e) begin
        if (bad == 0) begin
          firstCyc = r; firstGot = obs; firstExp = e;
        end
        bad++;
      end
      dones += int'(obs.done);
      lasts += int'(obs.last);
      @(posedge clk); #1;
    end
    stall = 1'b0; start = 1'b0;
    testsRun++;
    if (bad !== 0) begin
      testsFailed++;
      $display("FAIL %s seq: %0d bad cycles (required 0), first cycle %0d got %h required %h",
               name, bad, firstCyc, firstGot, firstExp);
    end
    testsRun++;
    if (dones !== 1) begin
      testsFailed++;
      $display("FAIL %s done_count: got %0d required 1", name, dones);
    end
    testsRun++;
    if (lasts !== passes) begin
      testsFailed++;
      $display("FAIL %s last_count: got %0d required %0d", name, lasts, passes);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; base = '0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (addr[0] !== 12'd0) begin testsFailed++; $display("FAIL rst_addr: got %h required 0", addr[0]); end
    testsRun++;
    if (passA !== 1'b0) begin testsFailed++; $display("FAIL rst_pass: got %b required 0", passA); end
    testsRun++;
    if (valid[0] !== 1'b0) begin testsFailed++; $display("FAIL rst_valid: got %b required 0", valid[0]); end
    testsRun++;
    if (strobe[0] !== 1'b0) begin testsFailed++; $display("FAIL rst_strobe: got %b required 0", strobe[0]); end
    testsRun++;
    if (last[0] !== 1'b0) begin testsFailed++; $display("FAIL rst_last: got %b required 0", last[0]); end
    testsRun++;
    if (busy[0] !== 1'b0) begin testsFailed++; $display("FAIL rst_busy: got %b required 0", busy[0]); end
    testsRun++;
    if (done[0] !== 1'b0) begin testsFailed++; $display("FAIL rst_done: got %b required 0", done[0]); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset_abort();
    int dones, busys;
    dones = 0; busys = 0;
    sel = 2; base = 12'd50; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1; #1;
    testsRun++;
    if (obs !== '0) begin
      testsFailed++;
      $display("FAIL abort_async_clear: got %h required 0", obs);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      dones += int'(obs.done);
      busys += int'(obs.busy);
    end
    @(posedge clk); #1;
    testsRun++;
    if (dones !== 0 || busys !== 0) begin
      testsFailed++;
      $display("FAIL abort_quiet: got done=%0d busy=%0d required 0/0", dones, busys);
    end
    run_seq("abort_restart", 2, 4, 3, 1, 200, 15, 0, 0, 0);
  endtask

  task automatic test_start_held();
    obs_t e;
    int   bad, dones;
    bad = 0; dones = 0;
    sel = 3; base = 12'd7; start = 1'b1;
    @(posedge clk); #1;
    for (int r = 1; r <= 12; r++) begin
      if (r == 9) start = 1'b0;
      e = expect_at(4, 1, 1, 7, (r <= 6) ? r : r - 6);
      @(negedge clk);
      if (obs !== e) begin
        if (bad == 0) $display("FAIL held_start cycle %0d: got %h required %h", r, obs, e);
        bad++;
      end
      dones += int'(obs.done);
      @(posedge clk); #1;
    end
    start = 1'b0;
    testsRun++;
    if (bad !== 0) begin
      testsFailed++;
      $display("FAIL held_start_seq: %0d bad cycles, required 0", bad);
    end
    testsRun++;
    if (dones !== 2) begin
      testsFailed++;
      $display("FAIL held_start_dones: got %0d required 2", dones);
    end
  endtask

  initial begin
    test_reset();
    run_seq("default", 0, 3780, 10, 1, 0, 37803, 0, 0, 0);
    run_seq("multipass", 1, 4, 1, 3, 100, 15, 0, 0, 0);
    run_seq("hold3_nostall", 2, 4, 3, 1, 0, 15, 0, 0, 0);
    run_seq("hold3_stall", 2, 4, 3, 1, 0, 20, 6, 5, 0);
    run_seq("wrap_midstart", 3, 4, 1, 1, 4094, 7, 0, 0, 2);
    test_reset_abort();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/svm_weight_addr_seq.md
# svm_weight_addr_seq

Parametrised SVM weight-ROM address sequencer for the HOG/SVM classifier. On a start pulse it sweeps `DEPTH` consecutive addresses from a latched base, holding each for `HOLD` cycles so the MAC can consume one weight per address. It repeats the sweep `PASSES` times, supports stalling, and flags the sample point, last address and completion. It sits between the window controller (start/stall) and the weight ROM plus SVM MAC (address/strobe).

## Interface
Parameters:
- `ADDR_W`, 12, ROM address width
- `DEPTH`, 3780, addresses per pass (HOG descriptor length); must satisfy 1 ≤ `DEPTH` ≤ 2^`ADDR_W`
- `HOLD`, 10, cycles each address is held; must be ≥ 1
- `PASSES`, 1, sweeps per start; must be ≥ 1
- `PASS_W`, derived as max(1, clog2(`PASSES`)), width of `oPASS`

Ports:
- `iClk` in 1: the single clock.
- `iRst` in 1: reset, asynchronous and active-high.
- `iStart` in 1: start pulse; sampled only in IDLE.
- `iStall` in 1: freezes sequencing while high.
- `iBase` in `ADDR_W`: base address, latched on accepted start.
- `oADDR` out `ADDR_W`: current ROM address.
- `oVALID` out 1: high in every RUN cycle.
- `oSTROBE` out 1: sample point, i.e. the last non-stalled hold cycle of an address.
- `oLAST` out 1: `oSTROBE` qualified with index == `DEPTH`-1.
- `oPASS` out `PASS_W`: current pass index.
- `oBUSY` out 1: high when state is not IDLE.
- `oDONE` out 1: one-cycle completion pulse.

## Operation
- Three states: IDLE, RUN and DONE.
- IDLE:
  - `iStart`=1 latches `iBase`, sets `oADDR`=`iBase`, index=0, hold count=0 and pass=0, then moves to RUN.
  - `iStall` is ignored in IDLE.
- RUN, with `iStall`=1: index, hold count, address and pass all hold their values. `oSTROBE` and `oLAST` are 0. `oVALID` stays 1.
- RUN, with `iStall`=0: hold count increments. When hold count == `HOLD`-1:
  - `oSTROBE`=1 and hold count returns to 0.
  - If index < `DEPTH`-1: index+1 and `oADDR`+1 on the next cycle.
  - If index == `DEPTH`-1: `oLAST`=1. Then, if pass < `PASSES`-1, pass+1, index=0 and `oADDR`=latched base. Otherwise go to DONE.
- DONE: `oDONE`=1 for exactly one cycle, then return to IDLE. `oADDR` keeps the final address.
- `iStart` is ignored in RUN and DONE. A start pulse in the same cycle as DONE is dropped.
- Address arithmetic is `ADDR_W` bits and wraps modulo 2^`ADDR_W`: base 4095 with `DEPTH` 2 yields 4095 then 0.
- `oSTROBE`/`oLAST` are combinational decodes of the registered state, hold count, index and `iStall`. All other outputs are registered or state decodes.
- Reset values, applied asynchronously: state=IDLE, `oADDR`=0, `oPASS`=0, index=0, hold count=0, `oVALID`=`oSTROBE`=`oLAST`=`oBUSY`=`oDONE`=0.
- Reset during RUN aborts the sweep with no `oDONE`.

## Timing
- Start sampled at edge E0 → RUN from cycle 1 with `oADDR`=base.
- First `oSTROBE` occurs in cycle `HOLD`.
- Without stalls each pass takes exactly `DEPTH`×`HOLD` RUN cycles. `oDONE` is asserted in cycle `PASSES`×`DEPTH`×`HOLD`+1.
- Each stalled cycle extends the total by exactly one cycle.
- `HOLD`=1: `oSTROBE` is asserted in every non-stalled RUN cycle and the address advances every cycle.
- Default config (3780, 10, 1): RUN occupies cycles 1..37800; `oDONE` is in cycle 37801.
- Earliest restart: `iStart` in the cycle after `oDONE` (state IDLE) is accepted.

## Structure
- Shared package `svm_pkg` holds:
  - `HOG_DESC_LEN`=3780
  - `SVM_ADDR_W`=12
  - `SVM_MAC_CYCLES`=10
  - the `seq_state_t` enum (IDLE, RUN, DONE)
- One sub-module, `svm_hold_counter`: a modulo-`HOLD` counter with enable (= RUN && !`iStall`), synchronous clear and a terminal-count output. The terminal count drives `oSTROBE`.
- Index, address and pass counters plus the FSM live in the top module.

## Test plan
- Defaults, base 0, no stall: `oSTROBE` in cycles 10, 20, …, 37800; `oADDR` steps 0→3779; `oLAST` only in cycle 37800; `oDONE` in cycle 37801 only; `oBUSY` low afterwards.
- `HOLD`=1, `DEPTH`=4, `PASSES`=3, base 100: address sequence 100..103 repeated three times; `oPASS` 0,1,2; `oLAST` ×3; `oDONE` in cycle 13.
- `DEPTH`=4, `HOLD`=3: `iStall` high for 5 cycles starting on the cycle that would strobe address 1. No strobe during the stall; address 1 is strobed on the first unstalled cycle; `oDONE` is 5 cycles later than the unstalled case (cycle 18 vs 13).
- Base 4094, `DEPTH`=4, `HOLD`=1: addresses 4094, 4095, 0, 1. Additionally, `iStart` pulsed mid-RUN is ignored and has no effect on the sequence.
- Assert `iRst` asynchronously mid-sweep (between clock edges): all outputs go to their reset values immediately; no `oDONE` is issued; a new `iStart` after release sweeps from the new base.
- `iStart` held high continuously: one sweep, one `oDONE`, and a new sweep begins the cycle after IDLE is re-entered.
